vec_lsu_mem_responder: RTL and testbench

- Memory-side responder for the vector LSU load/store interface.
- Accepts one word-granular load or store request at a time from the LSU (`lsu2mem_addr`, store data, byte strobes).
- Services the request against an internal word array after a parameterised latency, then returns `mem2lsu_data` with a one-cycle `mem_ack`.
- Serves as the data-memory model behind the vector processor in block and system benches.

---
 rtl/vec_lsu_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_vec_lsu_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vec_lsu_mem_responder.sv
// vec_lsu_mem_responder: word-array data memory behind the vector LSU.
// Accepts one load or store at a time. It services the request after
// READ_LAT cycles and then pulses mem_ack for one cycle.
// Optional build macro: VEC_MEM_ERR_CHK_EN. When it is defined, the block
// flags misaligned and out-of-range accesses on mem_err and suppresses them.
module vec_lsu_mem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int READ_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [XLEN-1:0]   lsu2mem_addr,
  input  logic [XLEN-1:0]   lsu2mem_data,
  input  logic [XLEN/8-1:0] wr_strb,
  output logic [XLEN-1:0]   mem2lsu_data,
  output logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int SW = XLEN / 8;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;

  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic [XLEN-1:0] req_addr_p1;
  logic [XLEN-1:0] req_data_p1;
  logic [SW-1:0]   req_strb_p1;
  logic            req_ld_p1;

  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [SW-1:0]   sel_strb;
  logic            sel_ld;
  logic [AW-1:0]   widx;
  logic            in_range;
  logic            misal;
  logic            wr_ok;
  logic            rd_ok;
  logic            err_now;
  logic            accept;
  logic            enter_resp;
  logic [XLEN-1:0] rd_word;

  // Byte-lane merge: strobed lanes take the new data, others keep the old word.
  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                  input logic [XLEN-1:0] new_w,
                                                  input logic [SW-1:0]   strb);
    logic [XLEN-1:0] res;
    res = old_w;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign accept = (state == IDLE) && (ld_req || st_req);

  // Operand select: a RESP entry straight from IDLE (READ_LAT==1) uses the live inputs.
  always_comb begin
    sel_addr = req_addr_p1;
    sel_data = req_data_p1;
    sel_strb = req_strb_p1;
    sel_ld   = req_ld_p1;
    if (state == IDLE) begin
      sel_addr = lsu2mem_addr;
      sel_data = lsu2mem_data;
      sel_strb = wr_strb;
      sel_ld   = ld_req;
    end
  end

  assign widx     = sel_addr[AW+1:2];
  assign in_range = (sel_addr[XLEN-1:AW+2] == '0);
  assign misal    = |sel_addr[1:0];

`ifdef VEC_MEM_ERR_CHK_EN
  assign err_now = misal | ~in_range;
  assign wr_ok   = in_range & ~misal;
  assign rd_ok   = in_range & ~misal;
`else
  logic unused_misal;
  assign unused_misal = misal;
  assign err_now      = 1'b0;
  assign wr_ok        = in_range;
  assign rd_ok        = in_range;
`endif

  assign rd_word    = rd_ok ? mem[widx] : '0;
  assign enter_resp = reset && (state != RESP) && (state_next == RESP);

  // Next-state and latency counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (ld_req || st_req) begin
          if (READ_LAT == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(READ_LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and counter; reset aborts any request that is in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // --- request capture stage: latch operands at acceptance (load wins a tie) ---
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr_p1 <= lsu2mem_addr;
      req_data_p1 <= lsu2mem_data;
      req_strb_p1 <= wr_strb;
      req_ld_p1   <= ld_req;
    end
  end

  // --- service stage: array write on RESP entry for stores ---
  always_ff @(posedge clk) begin
    if (enter_resp && !sel_ld && wr_ok) begin
      mem[widx] <= merge_bytes(mem[widx], sel_data, sel_strb);
    end
  end

  // Load data register holds the last load result; stores leave it untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem2lsu_data <= '0;
    end else if (enter_resp && sel_ld) begin
      mem2lsu_data <= rd_word;
    end
  end

`ifdef VEC_MEM_ERR_CHK_EN
  logic err_p2;

  // Error flag captured on RESP entry and exposed only while acking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_p2 <= 1'b0;
    end else if (enter_resp) begin
      err_p2 <= err_now;
    end
  end

  assign mem_err = (state == RESP) && err_p2;
`else
  logic unused_err;
  assign unused_err = err_now;
  assign mem_err    = 1'b0;
`endif

  assign mem_ack  = (state == RESP);
  assign mem_busy = (state != IDLE);

endmodule

// File: tb/tb_vec_lsu_mem_responder.sv
// Directed scoreboard bench for vec_lsu_mem_responder (READ_LAT 2 and 4 instances).
module tb_vec_lsu_mem_responder;

`ifdef VEC_MEM_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ld_req, st_req;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  strb;
  logic        ack, busy, err;

  logic        reset4, ld_req4, st_req4;
  logic [31:0] addr4, wdata4, rdata4;
  logic [3:0]  strb4;
  logic        ack4, busy4, err4;

  vec_lsu_mem_responder #(.XLEN(32), .MEM_DEPTH(1024), .READ_LAT(2)) dut (
    .clk(clk), .reset(reset), .ld_req(ld_req), .st_req(st_req),
    .lsu2mem_addr(addr), .lsu2mem_data(wdata), .wr_strb(strb),
    .mem2lsu_data(rdata), .mem_ack(ack), .mem_busy(busy), .mem_err(err)
  );

  vec_lsu_mem_responder #(.XLEN(32), .MEM_DEPTH(1024), .READ_LAT(4)) dut4 (
    .clk(clk), .reset(reset4), .ld_req(ld_req4), .st_req(st_req4),
    .lsu2mem_addr(addr4), .lsu2mem_data(wdata4), .wr_strb(strb4),
    .mem2lsu_data(rdata4), .mem_ack(ack4), .mem_busy(busy4), .mem_err(err4)
  );

  typedef struct {
    logic        is_ld;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_last = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack of the READ_LAT=2 instance consumes one expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk(e.is_ld ? "load_data" : "store_hold_data", rdata, e.data);
        chk("resp_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  task automatic wait_ack(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == exp_lat - 1) chk("busy_in_wait", {31'b0, busy}, 32'd1);
    end while (ack !== 1'b1 && n < 20);
    chk(tag, n, exp_lat);
  endtask

  task automatic do_req(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ld_req = ld; st_req = st; addr = a; wdata = d; strb = s;
    wait_ack("ack_latency", 3);
    ld_req = 1'b0; st_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
    sb.push_back('{is_ld: 1'b1, data: exp_d, err: exp_e});
    model_last = exp_d;
    do_req(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic exp_e);
    sb.push_back('{is_ld: 1'b0, data: model_last, err: exp_e});
    do_req(1'b0, 1'b1, a, d, s);
  endtask

  initial begin
    int n;
    int got;
    reset = 1'b0; ld_req = 1'b0; st_req = 1'b0; addr = '0; wdata = '0; strb = '0;
    reset4 = 1'b0; ld_req4 = 1'b0; st_req4 = 1'b0; addr4 = '0; wdata4 = '0; strb4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; reset4 = 1'b1;
    @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst4_ack", {31'b0, ack4}, 32'd0);
    chk("rst4_busy", {31'b0, busy4}, 32'd0);
    chk("rst4_err", {31'b0, err4}, 32'd0);

    // Store then load
    store(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    load(32'h10, 32'hDEADBEEF, 1'b0);

    // Partial strobe merge
    store(32'h20, 32'h11223344, 4'hF, 1'b0);
    store(32'h20, 32'hAABBCCDD, 4'h5, 1'b0);
    load(32'h20, 32'h11BB33DD, 1'b0);

    // Simultaneous load+store: load first, store re-presented afterwards
    store(32'h30, 32'h0, 4'hF, 1'b0);
    sb.push_back('{is_ld: 1'b1, data: 32'h0, err: 1'b0});
    model_last = 32'h0;
    @(negedge clk);
    ld_req = 1'b1; st_req = 1'b1; addr = 32'h30; wdata = 32'h00000077; strb = 4'hF;
    wait_ack("both_load_latency", 3);
    ld_req = 1'b0;
    sb.push_back('{is_ld: 1'b0, data: model_last, err: 1'b0});
    wait_ack("both_store_latency", 4);
    st_req = 1'b0;
    @(negedge clk);
    chk("both_ack_drop", {31'b0, ack}, 32'd0);
    load(32'h30, 32'h00000077, 1'b0);

    // Out-of-range: no wrap onto word 0, load returns 0
    store(32'h0, 32'h01010101, 4'hF, 1'b0);
    store(32'h1000, 32'hBADBAD00, 4'hF, ERR_EN);
    load(32'h1000, 32'h0, ERR_EN);
    load(32'h0, 32'h01010101, 1'b0);
    store(32'hFFC, 32'h7FFC0001, 4'hF, 1'b0);
    load(32'hFFC, 32'h7FFC0001, 1'b0);

    // Misaligned store
    store(32'h40, 32'hCAFEF00D, 4'hF, 1'b0);
    store(32'h42, 32'h12345678, 4'hF, ERR_EN);
    load(32'h40, ERR_EN ? 32'hCAFEF00D : 32'h12345678, 1'b0);

    // READ_LAT=4 instance: prime word 0x50
    @(negedge clk);
    st_req4 = 1'b1; addr4 = 32'h50; wdata4 = 32'hA; strb4 = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (ack4 !== 1'b1 && n < 20);
    chk("lat4_store_latency", n, 5);
    st_req4 = 1'b0;
    @(negedge clk);

    // Reset one cycle after acceptance aborts the store
    st_req4 = 1'b1; addr4 = 32'h50; wdata4 = 32'h5; strb4 = 4'hF;
    @(negedge clk);
    chk("lat4_busy_after_accept", {31'b0, busy4}, 32'd1);
    reset4 = 1'b0;
    @(negedge clk);
    st_req4 = 1'b0; reset4 = 1'b1;
    chk("lat4_busy_after_reset", {31'b0, busy4}, 32'd0);
    got = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack4 === 1'b1) got = 1;
    end
    chk("lat4_abort_no_ack", got, 0);

    ld_req4 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ack4 !== 1'b1 && n < 20);
    chk("lat4_load_latency", n, 5);
    chk("lat4_load_prior", rdata4, 32'hA);
    ld_req4 = 1'b0;
    @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
